// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared types and constants for the program loader: the loader FSM state
// encoding, the word geometry and a helper that maps a word index to the
// byte address written into instruction memory.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        COUNT_LO = 3'd1,
        COUNT_HI = 3'd2,
        DATA     = 3'd3,
        CHECK    = 3'd4,
        DONE     = 3'd5,
        ERROR    = 3'd6
    } loader_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BYTE_SHIFT = 2;

    // Byte address of word idx: the index is zero-extended to 32 bits
    // before the shift so no high index bits are lost.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [15:0] idx);
        return base + ({16'd0, idx} << BYTE_SHIFT);
    endfunction

endpackage

// File: rtl/word_assembler.sv
// word_assembler
// Collects accepted bytes into little-endian 32-bit words.
// Ports:
//   clock, reset_n  - clock and asynchronous active-low reset
//   clear_i         - restart at lane 0 (discards any partial word)
//   byte_en_i       - a byte is accepted this cycle
//   byte_i          - the accepted byte
//   last_byte_o     - the next accepted byte completes a word
//   word_valid_o    - registered one-cycle pulse: word_o holds a new word
//   word_o          - last completed word (held between pulses)
module word_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] lanes_q, lanes_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    // Lane steering: the byte lands in lane byte_idx; the fourth byte is
    // merged with the three held lanes straight into the output word.
    always_comb begin
        byte_idx_d   = byte_idx_q;
        lanes_d      = lanes_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear_i) begin
            byte_idx_d = 2'd0;
            lanes_d    = 24'd0;
        end else if (byte_en_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0:    lanes_d[7:0]   = byte_i;
                2'd1:    lanes_d[15:8]  = byte_i;
                2'd2:    lanes_d[23:16] = byte_i;
                default: begin
                    word_d       = {byte_i, lanes_q};
                    word_valid_d = 1'b1;
                end
            endcase
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q   <= 2'd0;
            lanes_q      <= 24'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            lanes_q      <= lanes_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign last_byte_o  = (byte_idx_q == LAST_LANE);
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives an image over a valid/ready byte link (16-bit LE word count,
// then 4*N data bytes, each word LSB first), writes each word into
// instruction memory at BASE_ADDR + 4*index, and holds the CPU in reset
// until the image has been loaded completely.
// Optional feature macro LOADER_CHECKSUM_EN: one trailing byte equal to the
// XOR of all data bytes; a mismatch ends the session in error.
// Ports:
//   clock, reset_n          - clock, asynchronous active-low reset
//   start                   - pulse, begins a session from IDLE/DONE/ERROR
//   byte_valid, byte_data   - incoming byte stream
//   byte_ready              - loader accepts a byte this cycle
//   mem_we, mem_addr, mem_wdata - instruction-memory write port
//   cpu_reset               - active-high CPU reset, low only once done
//   busy, done, error       - session status (done/error sticky)
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    loader_state_t state_q, state_d;
    logic          final_q, final_d;       // final word write in flight
    logic [7:0]    count_lo_q, count_lo_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic [31:0]   addr_q, addr_d;
    logic          byte_ready_q, byte_ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          cpu_reset_q, cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic        accept_s;
    logic [15:0] hdr_n_s;
    logic        hdr_bad_s;
    logic        last_byte_s;
    logic        last_word_s;
    logic        asm_en_s;
    logic        asm_clear_s;

    assign accept_s    = byte_valid && byte_ready_q;
    assign hdr_n_s     = {byte_data, count_lo_q};
    assign hdr_bad_s   = (hdr_n_s == 16'd0) || ({16'd0, hdr_n_s} > MAX_WORDS);
    assign last_word_s = (word_idx_q == (count_q - 16'd1));
    assign asm_en_s    = accept_s && (state_q == DATA);
    assign asm_clear_s = accept_s && (state_q == COUNT_HI);

    word_assembler u_word_assembler (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear_i      (asm_clear_s),
        .byte_en_i    (asm_en_s),
        .byte_i       (byte_data),
        .last_byte_o  (last_byte_s),
        .word_valid_o (mem_we),
        .word_o       (mem_wdata)
    );

    // Next-state logic. The write address is captured on the edge that
    // accepts a word's last byte so it lines up with the assembler pulse.
    // After the final word the FSM stays in DATA for the write cycle
    // (final_q) with byte_ready low, then moves to DONE.
    always_comb begin
        state_d    = state_q;
        final_d    = final_q;
        count_lo_d = count_lo_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d = COUNT_LO;
                    final_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            COUNT_LO: begin
                if (accept_s) begin
                    count_lo_d = byte_data;
                    state_d    = COUNT_HI;
                end else begin
                    state_d = state_q;
                end
            end
            COUNT_HI: begin
                if (accept_s) begin
                    count_d    = hdr_n_s;
                    word_idx_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                    if (hdr_bad_s) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            DATA: begin
                if (final_q) begin
                    state_d = DONE;
                    final_d = 1'b0;
                end else if (accept_s) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ byte_data;
`endif
                    if (last_byte_s) begin
                        addr_d     = word_addr(BASE_ADDR, word_idx_q);
                        word_idx_d = word_idx_q + 16'd1;
                        if (last_word_s) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = CHECK;
`else
                            final_d = 1'b1;
`endif
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (accept_s) begin
                    if (byte_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERROR;
                    end
                end else begin
                    state_d = state_q;
                end
`else
                state_d = ERROR;
`endif
            end
            default: state_d = ERROR;
        endcase
    end

    // Output decode from the next state so every status output is a flop.
    always_comb begin
        byte_ready_d = 1'b0;
        busy_d       = 1'b0;
        case (state_d)
            COUNT_LO, COUNT_HI, CHECK: begin
                byte_ready_d = 1'b1;
                busy_d       = 1'b1;
            end
            DATA: begin
                byte_ready_d = !final_d;
                busy_d       = 1'b1;
            end
            default: begin
                byte_ready_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    assign done_d      = (state_d == DONE);
    assign error_d     = (state_d == ERROR);
    assign cpu_reset_d = (state_d != DONE);

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            final_q      <= 1'b0;
            count_lo_q   <= 8'd0;
            count_q      <= 16'd0;
            word_idx_q   <= 16'd0;
            addr_q       <= BASE_ADDR;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cpu_reset_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            final_q      <= final_d;
            count_lo_q   <= count_lo_d;
            count_q      <= count_d;
            word_idx_q   <= word_idx_d;
            addr_q       <= addr_d;
            byte_ready_q <= byte_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cpu_reset_q  <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_addr   = addr_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Drives images over the byte link with random stalls and data, predicts
// the memory writes and the session outcome from the stream format, and
// compares the DUT against that prediction on every cycle.
`timescale 1ns/1ps
module tb_program_loader;

    localparam int unsigned MAXW = 64;
    localparam logic [31:0] BASE = 32'h0;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    program_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    typedef logic [7:0] bytes_t[$];

    int  checks = 0;
    int  errors = 0;
    int  cycle = 0;
    int  ready_waits = 0;
    bit  arm_done = 1'b0;
    bit  done_pending = 1'b0;
    wr_t exp_q[$];
    wr_t log_q[$];
    int  we_cyc_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of writes and status rules against the model.
    always @(negedge clock) begin
        wr_t w;
        cycle++;
        if (reset_n) begin
            check("cpu_reset_is_not_done", cpu_reset, !done);
            check("busy_with_status", busy && (done || error), 1'b0);
            check("done_and_error", done && error, 1'b0);
            check("write_expected", mem_we && (exp_q.size() == 0), 1'b0);
            if (done_pending) begin
                check("done_after_last_write", {done, cpu_reset}, 2'b10);
                done_pending = 1'b0;
            end
            if (mem_we) begin
                log_q.push_back('{mem_addr, mem_wdata});
                we_cyc_q.push_back(cycle);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("wr_addr", mem_addr, w.addr);
                    check("wr_data", mem_wdata, w.data);
                    if (exp_q.size() == 0 && arm_done) begin
                        done_pending = 1'b1;
                        arm_done     = 1'b0;
                    end
                end
            end
        end else begin
            check("no_write_in_reset", mem_we, 1'b0);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, BASE);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        check({tag, "_cpu_reset"}, cpu_reset, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        ready_waits += n;
        check("byte_accepted", byte_ready, 1'b1);
        @(negedge clock);
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
    endtask

    function automatic bytes_t build(input logic [15:0] n);
        bytes_t s;
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (n != 16'd0 && n <= MAXW) begin
            for (int i = 0; i < 4 * int'(n); i++) s.push_back(8'($urandom));
        end
        return s;
    endfunction

    function automatic bytes_t with_csum(input bytes_t s, input bit bad);
        bytes_t r;
        logic [7:0] x;
        r = s;
        x = 8'h00;
        for (int i = 2; i < s.size(); i++) x = x ^ s[i];
`ifdef LOADER_CHECKSUM_EN
        r.push_back(x ^ (bad ? 8'h01 : 8'h00));
`else
        if (bad) x = 8'h00;
`endif
        return r;
    endfunction

    // One load session; model prediction built from the stream rules.
    task automatic session(input bytes_t s, input int min_stall, input int max_stall,
                           input bit mid_start);
        logic [15:0] n;
        bit          bad;
        bit          ok;
        logic [7:0]  x;
        int          nsend;
        int          w;
        n   = {s[1], s[0]};
        bad = (n == 16'd0) || (n > MAXW);
        x   = 8'h00;
        if (!bad) begin
            for (int i = 0; i < int'(n); i++) begin
                exp_q.push_back('{BASE + 32'(4 * i),
                                  {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]}});
                for (int j = 0; j < 4; j++) x = x ^ s[2+4*i+j];
            end
        end
        ok = !bad;
`ifdef LOADER_CHECKSUM_EN
        if (!bad) ok = (s[2 + 4 * int'(n)] == x);
`else
        arm_done = ok;
`endif
        nsend = bad ? 2 : s.size();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 0; k < nsend; k++) begin
            repeat ($urandom_range(max_stall, min_stall)) @(negedge clock);
            if (mid_start && k == 4) start = 1'b1;
            send_byte(s[k]);
            start = 1'b0;
        end
        w = 0;
        while (!(done || error) && w < 20) begin
            @(negedge clock);
            w++;
        end
        check("session_end", done || error, 1'b1);
        check("sess_done", done, ok);
        check("sess_error", error, !ok);
        check("sess_cpu_reset", cpu_reset, !ok);
        check("sess_busy", busy, 1'b0);
        check("sess_ready", byte_ready, 1'b0);
        check("sess_writes_left", exp_q.size(), 0);
        exp_q.delete();
        arm_done = 1'b0;
    endtask

    task automatic random_sessions(input int count);
        int sel;
        logic [15:0] n;
        for (int r = 0; r < count; r++) begin
            sel = $urandom_range(9, 0);
            if (sel == 0) n = 16'd0;
            else if (sel == 1) n = 16'(MAXW + $urandom_range(300, 1));
            else n = 16'($urandom_range(10, 1));
            session(with_csum(build(n), $urandom_range(4, 0) == 0), 0,
                    $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bytes_t basic;
        bytes_t s;
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #12;
        check_reset_vals("por");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Basic load and its literal words.
        basic = '{8'h02, 8'h00, 8'hB3, 8'h00, 8'h31, 8'h00, 8'hB3, 8'h02, 8'h73, 8'h40};
        log_q.delete();
        session(with_csum(basic, 1'b0), 0, 0, 1'b0);
        check("basic_nwr", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("basic_w0", log_q[0], {32'h0, 32'h003100B3});
            check("basic_w1", log_q[1], {32'h4, 32'h407302B3});
        end

        // Reset in the middle of word 0.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hB3);
        send_byte(8'h00);
        #2 reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_idle_busy", busy, 1'b0);
        check("midrst_idle_cpu_reset", cpu_reset, 1'b1);

        // Gapped version of the basic load.
        log_q.delete();
        session(with_csum(basic, 1'b0), 1, 5, 1'b0);
        check("gap_nwr", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("gap_w0", log_q[0], {32'h0, 32'h003100B3});
            check("gap_w1", log_q[1], {32'h4, 32'h407302B3});
        end

        // Back-to-back N=3 stream.
        log_q.delete();
        we_cyc_q.delete();
        ready_waits = 0;
        session(with_csum(build(16'd3), 1'b0), 0, 0, 1'b0);
        check("stream_ready_waits", ready_waits, 0);
        check("stream_nwr", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("stream_a0", log_q[0].addr, 32'h0);
            check("stream_a1", log_q[1].addr, 32'h4);
            check("stream_a2", log_q[2].addr, 32'h8);
            check("stream_gap01", we_cyc_q[1] - we_cyc_q[0], 4);
            check("stream_gap12", we_cyc_q[2] - we_cyc_q[1], 4);
        end

        // Bad headers, stray valid bytes, then recovery.
        log_q.delete();
        session(build(16'd0), 0, 0, 1'b0);
        session(build(16'd65), 0, 0, 1'b0);
        check("bad_no_writes", log_q.size(), 0);
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        repeat (3) begin
            @(negedge clock);
            check("stray_ready", byte_ready, 1'b0);
            check("stray_error_held", error, 1'b1);
        end
        byte_valid = 1'b0;
        session(with_csum(build(16'd1), 1'b0), 0, 2, 1'b0);

        // Largest legal image.
        session(with_csum(build(16'(MAXW)), 1'b0), 0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6};
        session(s, 0, 0, 1'b0);
        check("csum_good_done", done, 1'b1);
        log_q.delete();
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7};
        session(s, 0, 0, 1'b0);
        check("csum_bad_error", {error, cpu_reset}, 2'b11);
        check("csum_bad_written", log_q.size(), 1);
`else
        s = build(16'd2);
        session(s, 0, 1, 1'b1);
`endif

        random_sessions(15);

        repeat (4) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
